// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 capture path: FSM encoding, VGA geometry
// and RGB565 field layout.
package ov7670_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_VS = 2'd0,
        ST_VBLANK  = 2'd1,
        ST_ACTIVE  = 2'd2
    } cap_state_t;

    localparam int OV_H_ACTIVE = 640;
    localparam int OV_V_ACTIVE = 480;
    localparam int OV_ADDR_W   = 19;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // The sensor sends R[4:0]G[5:3] first, then G[2:0]B[4:0].
    function automatic logic [15:0] rgb565_join(input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] w;
        w              = '0;
        w[R_MSB:R_LSB] = hi[7:3];
        w[G_MSB:G_LSB] = {hi[2:0], lo[7:5]};
        w[B_MSB:B_LSB] = lo[4:0];
        return w;
    endfunction

endpackage

// File: rtl/ov7670_byte_pair.sv
// Two-phase byte assembler: holds the first byte of a pair and presents the
// completed 16-bit word combinationally while the second byte is on the bus.
module ov7670_byte_pair
    import ov7670_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        sample_en,
    input  logic [7:0]  data,
    output logic [15:0] word,
    output logic        word_valid,
    output logic        phase
);

    logic       phase_reg;
    logic [7:0] high_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= 1'b0;
            high_reg  <= '0;
        end else if (clear) begin
            phase_reg <= 1'b0;
        end else if (sample_en) begin
            if (!phase_reg) begin
                high_reg <= data;
            end
            phase_reg <= ~phase_reg;
        end
    end

    assign word       = rgb565_join(high_reg, data);
    assign word_valid = sample_en & phase_reg & ~clear;
    assign phase      = phase_reg;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 frame capture: pairs camera bytes into RGB565 pixels, tracks x/y and
// produces frame-buffer writes plus frame start/done/error markers.
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = OV_H_ACTIVE,
    parameter int V_ACTIVE = OV_V_ACTIVE,
    parameter int ADDR_W   = OV_ADDR_W
) (
    input  logic              ov7670_pclk,
    input  logic              rst_n,
    input  logic              ov7670_vsync,
    input  logic              ov7670_href,
    input  logic [7:0]        ov7670_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [9:0]        pix_x,
    output logic [8:0]        pix_y,
    output logic              frame_start,
    output logic              frame_done,
    output logic              frame_err
);

    localparam logic [9:0]        H_LIM  = 10'(H_ACTIVE);
    localparam logic [8:0]        V_LIM  = 9'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);
    localparam logic [9:0]        X_MAX  = 10'd1023;
    localparam logic [8:0]        Y_MAX  = 9'd511;

    cap_state_t state_reg, state_next;
    logic       start_evt;
    logic       done_evt;

    logic              href_prev_reg;
    logic [9:0]        x_reg;
    logic [8:0]        y_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] line_base_reg;
    logic              err_reg;

    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [15:0]       wr_data_reg;
    logic [9:0]        pix_x_reg;
    logic [8:0]        pix_y_reg;
    logic              frame_start_reg;
    logic              frame_done_reg;
    logic              frame_err_reg;

    logic        in_active;
    logic        sample_en;
    logic        line_end;
    logic        pair_clear;
    logic [15:0] pair_word;
    logic        pair_valid;
    logic        pair_phase;
    logic        pix_ok;

    // A vsync rise in ACTIVE takes priority: any href in that cycle is ignored.
    assign in_active  = (state_reg == ST_ACTIVE) && !ov7670_vsync;
    assign sample_en  = in_active && ov7670_href;
    assign line_end   = in_active && href_prev_reg && !ov7670_href;
    assign pair_clear = (state_reg != ST_ACTIVE) || line_end;
    assign pix_ok     = (x_reg < H_LIM) && (y_reg < V_LIM);

    ov7670_byte_pair u_byte_pair (
        .clk        (ov7670_pclk),
        .rst_n      (rst_n),
        .clear      (pair_clear),
        .sample_en  (sample_en),
        .data       (ov7670_data),
        .word       (pair_word),
        .word_valid (pair_valid),
        .phase      (pair_phase)
    );

    always_ff @(posedge ov7670_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_WAIT_VS;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        start_evt  = 1'b0;
        done_evt   = 1'b0;
        unique case (state_reg)
            ST_WAIT_VS: begin
                if (ov7670_vsync) begin
                    state_next = ST_VBLANK;
                end
            end
            ST_VBLANK: begin
                if (!ov7670_vsync) begin
                    state_next = ST_ACTIVE;
                    start_evt  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ov7670_vsync) begin
                    state_next = ST_VBLANK;
                    done_evt   = 1'b1;
                end
            end
            default: begin
                state_next = ST_WAIT_VS;
            end
        endcase
    end

    always_ff @(posedge ov7670_pclk or negedge rst_n) begin
        if (!rst_n) begin
            href_prev_reg   <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            addr_reg        <= '0;
            line_base_reg   <= '0;
            err_reg         <= 1'b0;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
            pix_x_reg       <= '0;
            pix_y_reg       <= '0;
            frame_start_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            href_prev_reg   <= sample_en;
            wr_en_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_done_reg  <= 1'b0;

            if (start_evt) begin
                x_reg           <= '0;
                y_reg           <= '0;
                addr_reg        <= '0;
                line_base_reg   <= '0;
                err_reg         <= 1'b0;
                frame_err_reg   <= 1'b0;
                frame_start_reg <= 1'b1;
            end else if (done_evt) begin
                frame_done_reg <= 1'b1;
                frame_err_reg  <= err_reg || (y_reg != V_LIM);
            end else if (pair_valid) begin
                if (pix_ok) begin
                    wr_en_reg   <= 1'b1;
                    wr_addr_reg <= addr_reg;
                    wr_data_reg <= pair_word;
                    pix_x_reg   <= x_reg;
                    pix_y_reg   <= y_reg;
                end
                // Overlong lines keep counting so the line-end check sees them.
                if (x_reg != X_MAX) begin
                    x_reg    <= x_reg + 10'd1;
                    addr_reg <= addr_reg + 1'b1;
                end
            end else if (line_end) begin
                if ((x_reg != H_LIM) || pair_phase) begin
                    err_reg <= 1'b1;
                end
                x_reg         <= '0;
                line_base_reg <= line_base_reg + H_STEP;
                addr_reg      <= line_base_reg + H_STEP;
                if (y_reg != Y_MAX) begin
                    y_reg <= y_reg + 9'd1;
                end
            end
        end
    end

    assign wr_en       = wr_en_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;
    assign pix_x       = pix_x_reg;
    assign pix_y       = pix_y_reg;
    assign frame_start = frame_start_reg;
    assign frame_done  = frame_done_reg;
    assign frame_err   = frame_err_reg;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture on a 4x3 frame: table of frame shapes plus
// hand-written reset sequences, with a write/frame_done scoreboard.
module tb_ov7670_capture;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vsync;
    logic          href;
    logic [7:0]    data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [9:0]    pix_x;
    logic [8:0]    pix_y;
    logic          frame_start;
    logic          frame_done;
    logic          frame_err;

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .ov7670_pclk  (clk),
        .rst_n        (rst_n),
        .ov7670_vsync (vsync),
        .ov7670_href  (href),
        .ov7670_data  (data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic [9:0]    x;
        logic [8:0]    y;
        logic [31:0]   cyc;
    } wr_t;

    typedef struct {
        int nlines;
        int base_bytes;
        int sp_line;
        int sp_bytes;
        bit exp_err;
    } vec_t;

    wr_t         exp_q[$];
    bit          err_q[$];
    logic [31:0] cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          start_cnt = 0;
    int          start_exp = 0;
    logic [7:0]  byte_val = 8'h12;
    bit          last_err = 1'b0;
    bit          have_last = 1'b0;
    vec_t        vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every write and frame_done must match the head of its queue.
    always @(negedge clk) begin
        wr_t act;
        wr_t e;
        if (wr_en === 1'b1) begin
            act = '{addr: wr_addr, data: wr_data, x: pix_x, y: pix_y, cyc: cyc};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h x=%0d y=%0d, required no write",
                         wr_addr, wr_data, pix_x, pix_y);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h x=%0d y=%0d cyc=%0d, required addr=%0d data=%h x=%0d y=%0d cyc=%0d",
                             act.addr, act.data, act.x, act.y, act.cyc, e.addr, e.data, e.x, e.y, e.cyc);
                end else begin
                    $display("write addr=%0d data=%h x=%0d y=%0d ok", act.addr, act.data, act.x, act.y);
                end
            end
        end
        if (frame_done === 1'b1) begin
            checks++;
            if (err_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame_done: got frame_done=1 err=%0b, required none", frame_err);
            end else if (frame_err !== err_q[0]) begin
                errors++;
                $display("FAIL frame_err: got %0b, required %0b", frame_err, err_q[0]);
                void'(err_q.pop_front());
            end else begin
                $display("frame_done err=%0b ok", frame_err);
                void'(err_q.pop_front());
            end
        end
        if (frame_start === 1'b1) start_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    task automatic drive_line(input int l, input int nbytes, input bit expect_wr);
        logic [7:0] hi;
        hi = 8'h00;
        for (int b = 0; b < nbytes; b++) begin
            @(posedge clk); #1;
            href = 1'b1;
            data = byte_val;
            if (b % 2 == 0) begin
                hi = byte_val;
            end else if (expect_wr && (b / 2) < H && l < V) begin
                exp_q.push_back('{addr: AW'(l * H + b / 2), data: {hi, byte_val},
                                  x: 10'(b / 2), y: 9'(l), cyc: cyc + 1});
            end
            byte_val = byte_val + 8'h22;
        end
        @(posedge clk); #1;
        href = 1'b0;
        data = 8'($urandom);
        repeat (3) @(posedge clk);
    endtask

    task automatic frame_begin();
        @(posedge clk); #1;
        vsync = 1'b1;
        href  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (have_last) check("frame_err_hold", 64'(frame_err), 64'(last_err));
        vsync = 1'b0;
        start_exp++;
        repeat (2) @(posedge clk);
        #1;
        check("frame_start_count", 64'(start_cnt), 64'(start_exp));
        check("frame_err_cleared", 64'(frame_err), 64'd0);
    endtask

    task automatic frame_end(input bit err);
        @(posedge clk); #1;
        href  = 1'b0;
        vsync = 1'b1;
        err_q.push_back(err);
        last_err  = err;
        have_last = 1'b1;
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got cycle budget exhausted, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3, 8, -1, 0, 1'b0};   // clean 4x3 frame
        vecs[1] = '{3, 8, 1, 10, 1'b1};   // line 1 has five pixels
        vecs[2] = '{3, 8, 1, 7, 1'b1};    // line 1 has an odd byte count
        vecs[3] = '{2, 8, -1, 0, 1'b1};   // only two lines
        vecs[4] = '{3, 8, -1, 0, 1'b0};   // clean frame after an error frame
        vecs[5] = '{4, 8, -1, 0, 1'b1};   // extra line is suppressed

        rst_n = 1'b0;
        vsync = 1'b0;
        href  = 1'b0;
        data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({wr_en, wr_addr, wr_data, pix_x, pix_y, frame_start, frame_done, frame_err}), 64'd0);

        // Release in the middle of an active frame: nothing may be captured.
        rst_n = 1'b1;
        drive_line(0, 8, 1'b0);
        drive_line(1, 8, 1'b0);
        check("no_start_before_vsync", 64'(start_cnt), 64'd0);

        byte_val = 8'h12;
        for (int i = 0; i < 6; i++) begin
            frame_begin();
            for (int l = 0; l < vecs[i].nlines; l++) begin
                drive_line(l, (l == vecs[i].sp_line) ? vecs[i].sp_bytes : vecs[i].base_bytes, 1'b1);
            end
            frame_end(vecs[i].exp_err);
        end

        // Reset pulsed mid-line: immediate clear, no frame_done for that frame.
        frame_begin();
        drive_line(0, 8, 1'b1);
        begin
            logic [7:0] hi;
            hi = 8'h00;
            for (int b = 0; b < 4; b++) begin
                @(posedge clk); #1;
                href = 1'b1;
                data = byte_val;
                if (b % 2 == 0) hi = byte_val;
                else exp_q.push_back('{addr: AW'(H + b / 2), data: {hi, byte_val},
                                       x: 10'(b / 2), y: 9'd1, cyc: cyc + 1});
                byte_val = byte_val + 8'h22;
            end
        end
        @(posedge clk);
        @(negedge clk);
        #2;
        check("writes_drained_before_reset", 64'(exp_q.size()), 64'd0);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({wr_en, wr_addr, wr_data, pix_x, pix_y, frame_start, frame_done, frame_err}), 64'd0);
        have_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_line(2, 8, 1'b0);
        drive_line(3, 8, 1'b0);
        check("no_start_after_reset", 64'(start_cnt), 64'(start_exp));

        byte_val = 8'h12;
        frame_begin();
        for (int l = 0; l < V; l++) drive_line(l, 2 * H, 1'b1);
        frame_end(1'b0);

        repeat (6) @(posedge clk);
        #1;
        check("write_queue_empty", 64'(exp_q.size()), 64'd0);
        check("frame_done_queue_empty", 64'(err_q.size()), 64'd0);
        check("final_start_count", 64'(start_cnt), 64'(start_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
